// File: rtl/trace_frame_sequencer.sv
// Frame pixel sequencer: issues canvas coordinates at a fixed interval and writes returned
// colours back through a latency-matched tag line. Define TRACER_COLLISION_EN for collision_sig.
module trace_frame_sequencer #(
  parameter int unsigned COL_W          = 7,
  parameter int unsigned ROW_W          = 6,
  parameter int unsigned COL_MAX        = 79,
  parameter int unsigned ROW_MAX        = 59,
  parameter int unsigned ISSUE_INTERVAL = 37,
  parameter int unsigned PIPE_LATENCY   = 124,
  parameter int unsigned COLOR_W        = 12,
  parameter int unsigned CONTINUOUS     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  output logic               issue_valid,
  output logic [COL_W-1:0]   issue_col,
  output logic [ROW_W-1:0]   issue_row,
  input  logic [COLOR_W-1:0] ret_color,
  input  logic               ret_collision,
  output logic               wr_en,
  output logic [COL_W-1:0]   col_addr,
  output logic [ROW_W-1:0]   row_addr,
  output logic [COLOR_W-1:0] dout,
  output logic               frame_done,
  output logic [3:0]         collision_sig,
  output logic               busy
);

  localparam int unsigned TAG_W    = 1 + COL_W + ROW_W;
  localparam int unsigned INFL_MAX = (PIPE_LATENCY + ISSUE_INTERVAL - 1) / ISSUE_INTERVAL + 1;
  localparam int unsigned INFL_W   = $clog2(INFL_MAX + 1);
  localparam int unsigned CNT_W    = (ISSUE_INTERVAL > 1) ? $clog2(ISSUE_INTERVAL) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COL_MAX);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROW_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ISSUE_INTERVAL - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                stop_pend_q;
  logic [INFL_W-1:0]   infl_q;
  logic [TAG_W-1:0]    tag_q [PIPE_LATENCY];

  logic                tag_vld;
  logic [COL_W-1:0]    tag_col;
  logic [ROW_W-1:0]    tag_row;
  logic                tag_last;
  logic                last_issue;
  logic [COL_W-1:0]    col_nxt;
  logic [ROW_W-1:0]    row_nxt;

  assign {tag_vld, tag_col, tag_row} = tag_q[PIPE_LATENCY-1];
  assign tag_last   = (tag_col == COL_LAST) && (tag_row == ROW_LAST);
  assign last_issue = issue_valid && (issue_col == COL_LAST) && (issue_row == ROW_LAST);
  assign cnt_nxt    = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;

  // Raster-order successor of the coordinate being issued.
  always_comb begin
    col_nxt = issue_col + 1'b1;
    row_nxt = issue_row;
    if (issue_col == COL_LAST) begin
      col_nxt = '0;
      row_nxt = (issue_row == ROW_LAST) ? '0 : issue_row + 1'b1;
    end
  end

  // issue_valid mirrors "interval counter is zero" while in StIssue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      stop_pend_q <= 1'b0;
      issue_valid <= 1'b0;
      issue_col   <= '0;
      issue_row   <= '0;
      busy        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_q       <= '0;
          issue_col   <= '0;
          issue_row   <= '0;
          stop_pend_q <= 1'b0;
          if (start) begin
            state_q     <= StIssue;
            issue_valid <= 1'b1;
            busy        <= 1'b1;
          end
        end
        StIssue: begin
          cnt_q       <= cnt_nxt;
          issue_valid <= (cnt_nxt == '0);
          if (stop) begin
            stop_pend_q <= 1'b1;
          end
          if (issue_valid) begin
            issue_col <= col_nxt;
            issue_row <= row_nxt;
            if (last_issue && ((CONTINUOUS == 0) || stop_pend_q || stop)) begin
              state_q     <= StDrain;
              issue_valid <= 1'b0;
              stop_pend_q <= 1'b0;
              cnt_q       <= '0;
            end
          end
        end
        StDrain: begin
          if ((infl_q == '0) && !tag_vld) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          issue_valid <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= {issue_valid, issue_col, issue_row};
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      infl_q <= '0;
    end else if (issue_valid && !tag_vld) begin
      infl_q <= infl_q + 1'b1;
    end else if (!issue_valid && tag_vld) begin
      infl_q <= infl_q - 1'b1;
    end
  end

  // Addresses and colour hold between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      col_addr   <= '0;
      row_addr   <= '0;
      dout       <= '0;
    end else begin
      wr_en      <= tag_vld;
      frame_done <= tag_vld && tag_last;
      if (tag_vld) begin
        col_addr <= tag_col;
        row_addr <= tag_row;
        dout     <= ret_color;
      end
    end
  end

`ifdef TRACER_COLLISION_EN
  logic [3:0] acc_q;
  logic [3:0] hit;

  always_comb begin
    hit = 4'h0;
    if (tag_vld && ret_collision) begin
      hit = {tag_col == '0, tag_col == COL_LAST, 1'b1,
             (tag_row == '0) || (tag_row == ROW_LAST)};
    end
  end

  // The final pixel's hits fold into the published summary, not the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q         <= 4'h0;
      collision_sig <= 4'h0;
    end else if (tag_vld && tag_last) begin
      collision_sig <= acc_q | hit;
      acc_q         <= 4'h0;
    end else begin
      acc_q <= acc_q | hit;
    end
  end
`else
  logic unused_collision;
  assign unused_collision = ret_collision;
  assign collision_sig    = 4'h0;
`endif

endmodule

// File: tb/tb_trace_frame_sequencer.sv
// Scoreboard bench for trace_frame_sequencer: three configurations share one random stimulus
// stream; a cycle-level frame model predicts issues and queued write-backs.
module tb_trace_frame_sequencer;

  localparam int NCFG = 3;
  localparam int NCOL = 4;
  localparam int NROW = 2;
  localparam int NPIX = NCOL * NROW;
  localparam int TBL  = 4096;

  localparam int MIdle  = 0;
  localparam int MIssue = 1;
  localparam int MDrain = 2;

  function automatic int unsigned cfg_ii(int k);
    case (k)
      0:       return 4;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int unsigned cfg_pl(int k);
    case (k)
      0:       return 10;
      1:       return 10;
      default: return 3;
    endcase
  endfunction

  function automatic int unsigned cfg_cont(int k);
    return (k == 1) ? 1 : 0;
  endfunction

  typedef struct {
    int   due;
    int   col;
    int   row;
    int   dout;
    bit   last;
    int   sig;
  } wr_exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [11:0] ret_color;
  logic        ret_collision;

  logic        iv    [NCFG];
  logic [1:0]  icol  [NCFG];
  logic        irow  [NCFG];
  logic        wr    [NCFG];
  logic [1:0]  wcol  [NCFG];
  logic        wrow  [NCFG];
  logic [11:0] wdat  [NCFG];
  logic        fdone [NCFG];
  logic [3:0]  csig  [NCFG];
  logic        busy  [NCFG];

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    trace_frame_sequencer #(
      .COL_W          (2),
      .ROW_W          (1),
      .COL_MAX        (3),
      .ROW_MAX        (1),
      .ISSUE_INTERVAL (cfg_ii(g)),
      .PIPE_LATENCY   (cfg_pl(g)),
      .COLOR_W        (12),
      .CONTINUOUS     (cfg_cont(g))
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .stop          (stop),
      .issue_valid   (iv[g]),
      .issue_col     (icol[g]),
      .issue_row     (irow[g]),
      .ret_color     (ret_color),
      .ret_collision (ret_collision),
      .wr_en         (wr[g]),
      .col_addr      (wcol[g]),
      .row_addr      (wrow[g]),
      .dout          (wdat[g]),
      .frame_done    (fdone[g]),
      .collision_sig (csig[g]),
      .busy          (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec;
  int          n_err;
  int          cyc;
  logic [11:0] color_at [TBL];
  logic        coll_at  [TBL];

  // Model state per configuration
  int          m_mode [NCFG];
  int          m_pix  [NCFG];
  int          m_next [NCFG];
  int          m_pend [NCFG];
  int          m_due  [NCFG];
  logic [3:0]  m_acc  [NCFG];
  logic        exp_iv   [NCFG];
  int          exp_col  [NCFG];
  int          exp_row  [NCFG];
  logic        exp_busy [NCFG];
  wr_exp_t     exp_q [NCFG][$];

  int          t_e;
  int          t_col;
  int          t_row;
  logic [3:0]  t_bits;
  wr_exp_t     t_item;

  int          last_col [NCFG];
  int          last_row [NCFG];
  int          last_dat [NCFG];
  wr_exp_t     m_item;
  bit          m_exp_wr;
  bit          final_req;
  bit          final_done;

  // Reference model: pixel k of a frame issues at start+1+k*interval, returns latency later.
  always @(posedge clk) begin
    for (int k = 0; k < NCFG; k++) begin
      if (rst) begin
        m_mode[k] = MIdle;
        m_pix[k]  = 0;
        m_next[k] = 0;
        m_pend[k] = 0;
        m_due[k]  = 0;
        m_acc[k]  = 4'h0;
        exp_q[k].delete();
      end else begin
        case (m_mode[k])
          MIdle: begin
            if (start) begin
              m_mode[k] = MIssue;
              m_next[k] = cyc + 1;
              m_pix[k]  = 0;
              m_pend[k] = 0;
            end
          end
          MIssue: begin
            if (stop) m_pend[k] = 1;
            if (cyc == m_next[k]) begin
              t_col  = m_pix[k] % NCOL;
              t_row  = m_pix[k] / NCOL;
              t_e    = cyc + int'(cfg_pl(k));
              t_bits = 4'h0;
`ifdef TRACER_COLLISION_EN
              if (coll_at[t_e % TBL]) begin
                t_bits = {t_col == 0, t_col == NCOL - 1, 1'b1, (t_row == 0) || (t_row == NROW - 1)};
              end
`endif
              t_item.due  = t_e + 1;
              t_item.col  = t_col;
              t_item.row  = t_row;
              t_item.dout = int'(color_at[t_e % TBL]);
              t_item.last = (m_pix[k] == NPIX - 1);
              t_item.sig  = 0;
              if (t_item.last) begin
                t_item.sig = int'(m_acc[k] | t_bits);
                m_acc[k]   = 4'h0;
              end else begin
                m_acc[k] = m_acc[k] | t_bits;
              end
              exp_q[k].push_back(t_item);
              if (t_item.last) begin
                if (cfg_cont(k) == 0 || m_pend[k] != 0) begin
                  m_mode[k] = MDrain;
                  m_due[k]  = t_e + 1;
                  m_pend[k] = 0;
                end else begin
                  m_pix[k]  = 0;
                  m_next[k] = cyc + int'(cfg_ii(k));
                end
              end else begin
                m_pix[k]  = m_pix[k] + 1;
                m_next[k] = cyc + int'(cfg_ii(k));
              end
            end
          end
          default: begin
            if (cyc == m_due[k]) m_mode[k] = MIdle;
          end
        endcase
      end
      exp_iv[k]   = (m_mode[k] == MIssue) && (m_next[k] == cyc + 1);
      exp_col[k]  = m_pix[k] % NCOL;
      exp_row[k]  = m_pix[k] / NCOL;
      exp_busy[k] = (m_mode[k] != MIdle);
    end
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s cfg%0d cycle %0d: got %0h expected %0h", name, k, cyc, act, exp_v);
    end
  endtask

  // Monitor: compares DUT outputs mid-cycle against model expectations and the write queue.
  always @(negedge clk) begin
    for (int k = 0; k < NCFG; k++) begin
      if (rst) begin
        chk("reset_outputs", k, {iv[k], icol[k], irow[k], wr[k], wcol[k], wrow[k], wdat[k],
                                 fdone[k], csig[k], busy[k]}, 32'h0);
        last_col[k] = 0;
        last_row[k] = 0;
        last_dat[k] = 0;
      end else begin
        chk("issue_valid", k, iv[k], exp_iv[k]);
        if (exp_iv[k]) begin
          chk("issue_col", k, icol[k], exp_col[k]);
          chk("issue_row", k, irow[k], exp_row[k]);
        end
        chk("busy", k, busy[k], exp_busy[k]);
        m_exp_wr = (exp_q[k].size() > 0) && (exp_q[k][0].due == cyc);
        chk("wr_en", k, wr[k], m_exp_wr);
        if (m_exp_wr) begin
          m_item = exp_q[k].pop_front();
          chk("col_addr", k, wcol[k], m_item.col);
          chk("row_addr", k, wrow[k], m_item.row);
          chk("dout", k, wdat[k], m_item.dout);
          chk("frame_done", k, fdone[k], m_item.last);
          if (m_item.last) chk("collision_sig", k, csig[k], m_item.sig);
          last_col[k] = m_item.col;
          last_row[k] = m_item.row;
          last_dat[k] = m_item.dout;
        end else begin
          chk("frame_done_idle", k, fdone[k], 1'b0);
          chk("col_addr_hold", k, wcol[k], last_col[k]);
          chk("row_addr_hold", k, wrow[k], last_row[k]);
          chk("dout_hold", k, wdat[k], last_dat[k]);
        end
      end
    end
    if (final_req && !final_done) begin
      for (int k = 0; k < NCFG; k++) begin
        chk("queue_drained", k, exp_q[k].size(), 0);
        chk("busy_final", k, busy[k], 1'b0);
      end
      final_done = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    ret_color     = color_at[cyc % TBL];
    ret_collision = coll_at[cyc % TBL];
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < TBL; i++) begin
      color_at[i] = 12'($urandom);
      coll_at[i]  = (i >= 120) && ($urandom_range(3) == 0);
    end
    rst           = 1'b1;
    start         = 1'b0;
    stop          = 1'b0;
    ret_color     = color_at[0];
    ret_collision = coll_at[0];
    final_req     = 1'b0;
    final_done    = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
    pulse_stop();                  // ignored while idle
    repeat (3) tick();
    pulse_start();
    repeat (6) tick();
    pulse_start();                 // ignored while issuing
    repeat (45) tick();
    pulse_stop();                  // mid second frame of the continuous instance
    repeat (60) tick();
    pulse_start();
    repeat (19) tick();
    rst = 1'b1;                    // discard in-flight pixels
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    pulse_start();
    repeat (60) tick();
    pulse_stop();
    repeat (60) tick();
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(15) == 0);
      stop  = ($urandom_range(23) == 0);
      if ($urandom_range(499) == 0) begin
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    pulse_stop();
    repeat (150) tick();
    final_req = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    if (!final_done) begin
      $display("FAIL final_check not reached");
      $fatal(1, "final check not reached");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
